bcm_plane_shifter: RTL and testbench

//  Responder side of the BCM plane handshake. Shifts one row's bit-planes into the LED-matrix column drivers.
//  Per plane: blank, shift, latch, unblank, then start the timer (out_INIT) or resume it (out_CONTINUE).

---
 rtl/bcm_plane_shifter.sv | 200 ++++++++++++++++++++
 tb/tb_bcm_plane_shifter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcm_plane_shifter.sv
// bcm_plane_shifter: responder side of the BCM plane handshake. For each bit-plane
// of a row it blanks the panel, shifts COLUMNS pixels into the column drivers,
// latches, unblanks and starts (out_INIT) or resumes (out_CONTINUE) the BCM timer.
// Optional feature macro: BLANK_GUARD_EN inserts GUARD_CYCLES blanked cycles
// between the latch strobe and the unblank.
// All outputs are registered: they are computed from the next state and loaded
// on the same edge as the state register.
module bcm_plane_shifter #(
  parameter int COLUMNS      = 64,
  parameter int PLANES       = 4,
  parameter int ADDR_WIDTH   = 6,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_START,
  input  logic                  in_NEXT_PLANE,
  input  logic                  in_FINISH,
  output logic                  out_INIT,
  output logic                  out_CONTINUE,
  output logic [ADDR_WIDTH-1:0] out_ADDR,
  input  logic [3*PLANES-1:0]   in_DATA,
  output logic                  out_R,
  output logic                  out_G,
  output logic                  out_B,
  output logic                  out_SCLK,
  output logic                  out_LATCH,
  output logic                  out_OE_n,
  output logic                  out_BUSY,
  output logic                  out_DONE
);

  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;

  typedef enum logic [3:0] {
    IDLE, FETCH1, FETCH2, SH_LO, SH_HI, LATCH, GUARD, ARM,
    DISPLAY, BLANK, TAIL, WAIT_FIN, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] c_q, c_d, c_inc;
  logic [PW-1:0]         p_q, p_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  r_q, r_d, g_q, g_d, b_q, b_d;
  logic                  sclk_q, sclk_d, latch_q, latch_d, oe_n_q, oe_n_d;
  logic                  init_q, init_d, cont_q, cont_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [PLANES-1:0]     r_planes, g_planes, b_planes;

`ifdef BLANK_GUARD_EN
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  logic [GW-1:0] gcnt_q, gcnt_d;
`endif

  assign r_planes = in_DATA[3*PLANES-1 -: PLANES];
  assign g_planes = in_DATA[2*PLANES-1 -: PLANES];
  assign b_planes = in_DATA[PLANES-1:0];
  assign c_inc    = c_q + ADDR_WIDTH'(1);

  // Next-state logic plus the registered-output values for the state being entered.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    p_d     = p_q;
    addr_d  = addr_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
`ifdef BLANK_GUARD_EN
    gcnt_d  = gcnt_q;
`endif
    case (state_q)
      IDLE: if (in_START) begin
        state_d = FETCH1;
        c_d     = '0;
        addr_d  = '0;
      end
      FETCH1: state_d = FETCH2;
      // in_DATA now holds column 0; prefetch column 1 while it is shifted out.
      FETCH2: begin
        state_d = SH_LO;
        c_d     = '0;
        addr_d  = ADDR_WIDTH'(1);
        r_d     = r_planes[p_q];
        g_d     = g_planes[p_q];
        b_d     = b_planes[p_q];
      end
      SH_LO: state_d = SH_HI;
      SH_HI: begin
        if (c_q == ADDR_WIDTH'(COLUMNS - 1)) begin
          state_d = LATCH;
        end else begin
          state_d = SH_LO;
          c_d     = c_inc;
          addr_d  = c_inc + ADDR_WIDTH'(1);
          r_d     = r_planes[p_q];
          g_d     = g_planes[p_q];
          b_d     = b_planes[p_q];
        end
      end
`ifdef BLANK_GUARD_EN
      LATCH: begin
        state_d = GUARD;
        gcnt_d  = '0;
      end
      GUARD: begin
        if (gcnt_q == GW'(GUARD_CYCLES - 1)) state_d = ARM;
        else                                  gcnt_d  = gcnt_q + GW'(1);
      end
`else
      LATCH: state_d = ARM;
      GUARD: state_d = ARM;
`endif
      ARM: state_d = DISPLAY;
      // NEXT_PLANE wins over FINISH here simply because FINISH is not looked at.
      DISPLAY: if (in_NEXT_PLANE) begin
        if (p_q == PW'(PLANES - 1)) begin
          state_d = BLANK;
        end else begin
          state_d = FETCH1;
          p_d     = p_q + PW'(1);
          c_d     = '0;
          addr_d  = '0;
        end
      end
      BLANK:    state_d = TAIL;
      TAIL:     state_d = WAIT_FIN;
      WAIT_FIN: if (in_FINISH) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        p_d     = '0;
      end
      default:  state_d = IDLE;
    endcase

    sclk_d  = (state_d == SH_HI);
    latch_d = (state_d == LATCH);
    oe_n_d  = !((state_d == ARM) || (state_d == DISPLAY));
    init_d  = (state_d == ARM) && (p_d == '0);
    cont_d  = ((state_d == ARM) && (p_d != '0)) || (state_d == TAIL);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // State, counters and all output registers; reset blanks the panel at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      p_q     <= '0;
      addr_q  <= '0;
      r_q     <= 1'b0;
      g_q     <= 1'b0;
      b_q     <= 1'b0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
      oe_n_q  <= 1'b1;
      init_q  <= 1'b0;
      cont_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      p_q     <= p_d;
      addr_q  <= addr_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      sclk_q  <= sclk_d;
      latch_q <= latch_d;
      oe_n_q  <= oe_n_d;
      init_q  <= init_d;
      cont_q  <= cont_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef BLANK_GUARD_EN
  // Guard-interval counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) gcnt_q <= '0;
    else      gcnt_q <= gcnt_d;
  end
`endif

  assign out_INIT     = init_q;
  assign out_CONTINUE = cont_q;
  assign out_ADDR     = addr_q;
  assign out_R        = r_q;
  assign out_G        = g_q;
  assign out_B        = b_q;
  assign out_SCLK     = sclk_q;
  assign out_LATCH    = latch_q;
  assign out_OE_n     = oe_n_q;
  assign out_BUSY     = busy_q;
  assign out_DONE     = done_q;

endmodule

// File: tb/tb_bcm_plane_shifter.sv
// Bench for bcm_plane_shifter: 4 columns x 4 planes fed from a 1-cycle-latency ROM.
module tb_bcm_plane_shifter;
  localparam int C  = 4;
  localparam int P  = 4;
  localparam int AW = 6;
  localparam int GC = 2;
`ifdef BLANK_GUARD_EN
  localparam int G = GC;
`else
  localparam int G = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_START = 1'b0, in_NEXT_PLANE = 1'b0, in_FINISH = 1'b0;
  logic [3*P-1:0] in_DATA = '0;
  logic [AW-1:0] out_ADDR;
  logic out_INIT, out_CONTINUE, out_R, out_G, out_B, out_SCLK, out_LATCH;
  logic out_OE_n, out_BUSY, out_DONE;

  logic [3*P-1:0] rom [0:C-1];
  int tests = 0;
  int fails = 0;

  bcm_plane_shifter #(.COLUMNS(C), .PLANES(P), .ADDR_WIDTH(AW), .GUARD_CYCLES(GC)) dut (
    .clk(clk), .rst(rst), .in_START(in_START), .in_NEXT_PLANE(in_NEXT_PLANE),
    .in_FINISH(in_FINISH), .out_INIT(out_INIT), .out_CONTINUE(out_CONTINUE),
    .out_ADDR(out_ADDR), .in_DATA(in_DATA), .out_R(out_R), .out_G(out_G),
    .out_B(out_B), .out_SCLK(out_SCLK), .out_LATCH(out_LATCH), .out_OE_n(out_OE_n),
    .out_BUSY(out_BUSY), .out_DONE(out_DONE)
  );

  always #5 clk = ~clk;

  // Frame-buffer model: synchronous read, data one cycle after the address.
  always @(posedge clk) in_DATA <= rom[out_ADDR % C];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_spec_rom();
    for (int c = 0; c < C; c++) begin
      logic [P-1:0] rv, gv;
      rv = P'(c);
      gv = ~rv;
      rom[c] = {rv, gv, 4'hA};
    end
  endtask

  task automatic load_random_rom();
    for (int c = 0; c < C; c++) rom[c] = (3*P)'($urandom);
  endtask

  // Expected colour bit: plane p of column c, straight from the ROM contents.
  function automatic bit exp_bit(input int c, input int colour, input int p);
    logic [3*P-1:0] w;
    w = rom[c];
    return w[(2 - colour) * P + p];
  endfunction

  task automatic check_quiet(input string name);
    tests++;
    if (out_OE_n !== 1'b1 || out_SCLK !== 1'b0 || out_LATCH !== 1'b0 || out_BUSY !== 1'b0 ||
        out_INIT !== 1'b0 || out_CONTINUE !== 1'b0 || out_DONE !== 1'b0) begin
      fails++;
      $display("FAIL %s: oe_n=%b sclk=%b latch=%b busy=%b init=%b cont=%b done=%b, required 1 0 0 0 0 0 0",
               name, out_OE_n, out_SCLK, out_LATCH, out_BUSY, out_INIT, out_CONTINUE, out_DONE);
    end
  endtask

  // The trigger (START or NEXT_PLANE) must already be driven; k counts cycles after it.
  task automatic capture_plane(input int p, input bit spur);
    int latch_at, arm_at, blank_bad, sclk_n;
    bit arm_init;
    bit qr[$], qg[$], qb[$];
    latch_at = -1; arm_at = -1; blank_bad = 0; sclk_n = 0; arm_init = 0;
    for (int k = 1; k <= 40 && arm_at < 0; k++) begin
      step();
      in_START = 0; in_NEXT_PLANE = 0; in_FINISH = 0;
      if (spur && (k == 3 || k == 6)) begin in_START = 1; in_NEXT_PLANE = 1; end
      if (spur && k == 8) in_FINISH = 1;
      if (out_INIT === 1'b1 || out_CONTINUE === 1'b1) begin
        arm_at = k; arm_init = out_INIT;
        if (out_OE_n !== 1'b0) blank_bad++;
      end else if (out_OE_n !== 1'b1) blank_bad++;
      if (out_SCLK === 1'b1) begin
        sclk_n++; qr.push_back(out_R); qg.push_back(out_G); qb.push_back(out_B);
      end
      if (out_LATCH === 1'b1 && latch_at < 0) latch_at = k;
    end
    in_START = 0; in_NEXT_PLANE = 0; in_FINISH = 0;
    tests++;
    if (sclk_n != C) begin fails++; $display("FAIL sclk_count p%0d: got %0d, required %0d", p, sclk_n, C); end
    for (int c = 0; c < C && c < sclk_n; c++) begin
      tests++;
      if (qr[c] !== exp_bit(c, 0, p) || qg[c] !== exp_bit(c, 1, p) || qb[c] !== exp_bit(c, 2, p)) begin
        fails++;
        $display("FAIL rgb p%0d col%0d: got %b%b%b, required %b%b%b", p, c, qr[c], qg[c], qb[c],
                 exp_bit(c, 0, p), exp_bit(c, 1, p), exp_bit(c, 2, p));
      end
    end
    tests++;
    if (latch_at != 2*C + 3) begin fails++; $display("FAIL latch_cycle p%0d: got %0d, required %0d", p, latch_at, 2*C+3); end
    tests++;
    if (arm_at != 2*C + 4 + G) begin fails++; $display("FAIL arm_cycle p%0d: got %0d, required %0d", p, arm_at, 2*C+4+G); end
    tests++;
    if (arm_at > 0 && arm_init != (p == 0)) begin
      fails++; $display("FAIL init_vs_continue p%0d: init=%b, required %b", p, arm_init, (p == 0));
    end
    tests++;
    if (blank_bad != 0) begin fails++; $display("FAIL blanking p%0d: %0d bad OE_n cycles, required 0", p, blank_bad); end
  endtask

  task automatic hold_display(input int n, input bit spur);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      in_FINISH = spur ? 1'($urandom) : 1'b0;
      step();
      in_FINISH = 0;
      if (out_OE_n !== 1'b0 || out_BUSY !== 1'b1 || out_INIT !== 1'b0 || out_CONTINUE !== 1'b0 ||
          out_SCLK !== 1'b0 || out_DONE !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL display_hold: %0d bad cycles, required 0", bad); end
  endtask

  task automatic test_tail();
    int wait_n;
    in_NEXT_PLANE = 1;
    step();
    in_NEXT_PLANE = 0;
    in_FINISH = 1;
    tests++;
    if (out_OE_n !== 1'b1 || out_CONTINUE !== 1'b0 || out_SCLK !== 1'b0) begin
      fails++; $display("FAIL tail_blank: oe_n=%b cont=%b sclk=%b, required 1 0 0", out_OE_n, out_CONTINUE, out_SCLK);
    end
    step();
    tests++;
    if (out_CONTINUE !== 1'b1 || out_OE_n !== 1'b1 || out_SCLK !== 1'b0 || out_DONE !== 1'b0) begin
      fails++; $display("FAIL tail_continue: cont=%b oe_n=%b sclk=%b done=%b, required 1 1 0 0",
                        out_CONTINUE, out_OE_n, out_SCLK, out_DONE);
    end
    step();
    in_FINISH = 0;
    tests++;
    if (out_CONTINUE !== 1'b0 || out_DONE !== 1'b0 || out_BUSY !== 1'b1 || out_OE_n !== 1'b1) begin
      fails++; $display("FAIL wait_fin: cont=%b done=%b busy=%b oe_n=%b, required 0 0 1 1",
                        out_CONTINUE, out_DONE, out_BUSY, out_OE_n);
    end
    wait_n = $urandom_range(0, 3);
    repeat (wait_n) step();
    in_FINISH = 1;
    step();
    in_FINISH = 0;
    tests++;
    if (out_DONE !== 1'b1 || out_BUSY !== 1'b1) begin
      fails++; $display("FAIL done_pulse: done=%b busy=%b, required 1 1", out_DONE, out_BUSY);
    end
    step();
    check_quiet("after_done");
  endtask

  task automatic run_row(input bit spur);
    in_START = 1;
    capture_plane(0, spur);
    for (int p = 0; p < P - 1; p++) begin
      hold_display($urandom_range(1, 4), spur);
      in_NEXT_PLANE = 1;
      if (p == 1) in_FINISH = 1;
      capture_plane(p + 1, spur);
    end
    hold_display($urandom_range(1, 4), spur);
    test_tail();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset_state");
    @(negedge clk);
    rst = 1;
    step();
    in_NEXT_PLANE = 1; in_FINISH = 1;
    step();
    in_NEXT_PLANE = 0; in_FINISH = 0;
    step();
    check_quiet("idle_ignores_pulses");
  endtask

  task automatic test_shift();
    load_spec_rom();
    run_row(1'b0);
  endtask

  task automatic test_spurious();
    load_random_rom();
    run_row(1'b1);
  endtask

  task automatic test_reset_mid_shift();
    int k;
    load_spec_rom();
    in_START = 1;
    step();
    in_START = 0;
    k = 0;
    while (out_SCLK !== 1'b1 && k < 20) begin step(); k++; end
    tests++;
    if (out_SCLK !== 1'b1) begin fails++; $display("FAIL reach_sh_hi: sclk=%b, required 1", out_SCLK); end
    #2 rst = 0;
    #1 check_quiet("async_reset_mid_shift");
    @(posedge clk);
    #3 rst = 1;
    repeat (3) step();
    check_quiet("after_reset_release");
    run_row(1'b0);
  endtask

  task automatic test_back_to_back();
    load_random_rom();
    run_row(1'b0);
    load_spec_rom();
    run_row(1'b1);
  endtask

  initial begin
    load_spec_rom();
    test_reset();
    test_shift();
    test_spurious();
    test_reset_mid_shift();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
